fetch_sequencer: RTL and testbench

Multi-cycle fetch/execute sequencer that owns the program counter and drives instruction-memory fetches over a req/ack handshake. It holds each fetched instruction for the datapath until the datapath signals completion. It then commits the next PC: PC+4, or PC+4+(extSigno<<2) when SaltoCond & oZero. It sits between the instruction memory and the processor datapath/control unit, and replaces free-running PC update with a sequenced, stall-tolerant one.

---
 rtl/fetch_sequencer_pkg.sv | 17 +
 rtl/fetch_sequencer_if.sv | 33 +++
 rtl/fetch_sequencer_next_pc_calc.sv | 23 ++
 rtl/fetch_sequencer.sv | 148 ++++++++++++++
 tb/tb_fetch_sequencer.sv | 334 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_sequencer_pkg.sv
// fetch_seq_pkg: shared types and constants for the fetch sequencer.
//   seqState_t : sequencer FSM states (IDLE, FETCH, EXEC, FAULT)
//   PC_INCR    : sequential PC step (one 32-bit instruction)
//   WAIT_W     : width of the fetch wait counter (covers MAX_WAIT up to 255)
package fetch_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2,
        FAULT = 2'd3
    } seqState_t;

    localparam logic [31:0] PC_INCR = 32'd4;
    localparam int          WAIT_W  = 8;

endpackage

// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if: bundles the instruction-memory handshake, the datapath
// hand-off and the status/counter outputs of the fetch sequencer.
//   master : sequencer side (drives imem_req/imem_addr, instr, pc, status)
//   slave  : environment side (memory + datapath + control)
interface fetch_sequencer_if;

    logic        run;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic        exec_done;
    logic        SaltoCond;
    logic        oZero;
    logic [31:0] extSigno;
    logic [31:0] pc;
    logic        fault;
    logic [31:0] instret;
    logic [31:0] stall_cycles;

    modport master (
        input  run, imem_ack, imem_rdata, exec_done, SaltoCond, oZero, extSigno,
        output imem_req, imem_addr, instr, instr_valid, pc, fault, instret, stall_cycles
    );

    modport slave (
        output run, imem_ack, imem_rdata, exec_done, SaltoCond, oZero, extSigno,
        input  imem_req, imem_addr, instr, instr_valid, pc, fault, instret, stall_cycles
    );

endinterface

// File: rtl/fetch_sequencer_next_pc_calc.sv
// next_pc_calc: combinational next-PC generator.
//   pc        : current program counter
//   SaltoCond : branch instruction flag
//   oZero     : ALU zero flag
//   extSigno  : sign-extended branch offset in words
//   next_pc   : pc + 4, plus (extSigno << 2) when the branch is taken
// All arithmetic is 32-bit modulo; the word-to-byte shift drops extSigno[31:30].
module next_pc_calc
    import fetch_seq_pkg::*;
(
    input  logic [31:0] pc,
    input  logic        SaltoCond,
    input  logic        oZero,
    input  logic [31:0] extSigno,
    output logic [31:0] next_pc
);

    logic [31:0] brOffset;

    assign brOffset = (SaltoCond & oZero) ? (extSigno << 2) : 32'd0;
    assign next_pc  = pc + PC_INCR + brOffset;

endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: multi-cycle fetch/execute sequencer owning the PC.
//   clk   : system clock, rising edge
//   reset : asynchronous, active-high reset
//   bus   : fetch_sequencer_if.master
//           run              - allow new fetches to start
//           imem_req/addr    - fetch request; addr always equals pc
//           imem_ack/rdata   - memory accept + instruction word
//           instr/instr_valid- latched instruction held for the datapath
//           exec_done        - datapath finished; commits next pc
//           SaltoCond/oZero/extSigno - branch decision, sampled on exec_done
//           pc, fault        - program counter, sticky fetch timeout
//           instret/stall_cycles - perf counters
// Build option: define PERF_CNT_EN to implement instret/stall_cycles;
// otherwise both outputs are tied to zero and no counter flops exist.
module fetch_sequencer
    import fetch_seq_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          MAX_WAIT = 15
) (
    input  logic              clk,
    input  logic              reset,
    fetch_sequencer_if.master bus
);

    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

    seqState_t         state, stateNxt;
    logic [31:0]       pcQ, pcNxt;
    logic [31:0]       instrQ, instrNxt;
    logic              reqQ, reqNxt;
    logic              validQ, validNxt;
    logic              faultQ, faultNxt;
    logic [WAIT_W-1:0] waitCnt, waitNxt;
    logic [31:0]       nextPc;

    next_pc_calc uNextPc (
        .pc        (pcQ),
        .SaltoCond (bus.SaltoCond),
        .oZero     (bus.oZero),
        .extSigno  (bus.extSigno),
        .next_pc   (nextPc)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            pcQ     <= RESET_PC;
            instrQ  <= 32'd0;
            reqQ    <= 1'b0;
            validQ  <= 1'b0;
            faultQ  <= 1'b0;
            waitCnt <= '0;
        end else begin
            state   <= stateNxt;
            pcQ     <= pcNxt;
            instrQ  <= instrNxt;
            reqQ    <= reqNxt;
            validQ  <= validNxt;
            faultQ  <= faultNxt;
            waitCnt <= waitNxt;
        end
    end

    always_comb begin
        stateNxt = state;
        pcNxt    = pcQ;
        instrNxt = instrQ;
        reqNxt   = reqQ;
        validNxt = validQ;
        faultNxt = faultQ;
        waitNxt  = waitCnt;
        case (state)
            IDLE: begin
                if (bus.run) begin
                    stateNxt = FETCH;
                    reqNxt   = 1'b1;
                end
            end
            FETCH: begin
                // An ack in the timeout cycle still wins over the fault.
                if (bus.imem_ack) begin
                    stateNxt = EXEC;
                    instrNxt = bus.imem_rdata;
                    validNxt = 1'b1;
                    reqNxt   = 1'b0;
                    waitNxt  = '0;
                end else if (waitCnt == WAIT_LAST) begin
                    stateNxt = FAULT;
                    reqNxt   = 1'b0;
                    faultNxt = 1'b1;
                end else begin
                    waitNxt = waitCnt + 1'b1;
                end
            end
            EXEC: begin
                if (bus.exec_done) begin
                    pcNxt    = nextPc;
                    validNxt = 1'b0;
                    if (bus.run) begin
                        stateNxt = FETCH;
                        reqNxt   = 1'b1;
                    end else begin
                        stateNxt = IDLE;
                    end
                end
            end
            FAULT: begin
                // Terminal until reset; pc stays frozen.
                reqNxt   = 1'b0;
                validNxt = 1'b0;
                faultNxt = 1'b1;
            end
            default: stateNxt = IDLE;
        endcase
    end

    assign bus.imem_req    = reqQ;
    assign bus.imem_addr   = pcQ;
    assign bus.instr       = instrQ;
    assign bus.instr_valid = validQ;
    assign bus.pc          = pcQ;
    assign bus.fault       = faultQ;

`ifdef PERF_CNT_EN
    logic [31:0] instretQ;
    logic [31:0] stallQ;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instretQ <= 32'd0;
            stallQ   <= 32'd0;
        end else begin
            if (state == EXEC && bus.exec_done)
                instretQ <= instretQ + 32'd1;
            if (state == FETCH && !bus.imem_ack)
                stallQ <= stallQ + 32'd1;
        end
    end

    assign bus.instret      = instretQ;
    assign bus.stall_cycles = stallQ;
`else
    assign bus.instret      = 32'd0;
    assign bus.stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: self-checking bench for fetch_sequencer.
// Expected fetch addresses and instruction words go into queues when the
// stimulus is chosen and are popped when the DUT requests / presents them.
module tb_fetch_sequencer;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam int          MAXW   = 15;

    logic clk = 1'b0;
    logic reset = 1'b1;

    fetch_sequencer_if bus();

    fetch_sequencer #(.RESET_PC(RST_PC), .MAX_WAIT(MAXW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int          nTests = 0;
    int          nFail  = 0;
    logic [31:0] addrQ[$];
    logic [31:0] instrQ[$];
    logic [31:0] mPc;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    task automatic idleInputs();
        bus.run        = 1'b0;
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = 32'd0;
        bus.exec_done  = 1'b0;
        bus.SaltoCond  = 1'b0;
        bus.oZero      = 1'b0;
        bus.extSigno   = 32'd0;
    endtask

    task automatic doReset();
        reset = 1'b1;
        idleInputs();
        step();
        step();
        reset = 1'b0;
        mPc = RST_PC;
        addrQ.delete();
        instrQ.delete();
    endtask

    task automatic waitReq(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.imem_req === 1'b1) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    // One full instruction: fetch (ack after ackDly idle cycles), execute,
    // commit with the given branch inputs; run is set to runAfter at commit.
    task automatic doInstr(input int ackDly, input logic br, input logic zr,
                           input logic [31:0] ext, input logic runAfter);
        bit          ok;
        logic [31:0] expA;
        logic [31:0] expI;
        waitReq(ok);
        nTests++;
        if (!ok || addrQ.size() == 0) begin
            nFail++;
            $display("FAIL fetch_req: imem_req=%b queued=%0d, required req=1 with a queued address",
                     bus.imem_req, addrQ.size());
            return;
        end
        expA = addrQ.pop_front();
        if (bus.imem_addr !== expA) begin
            nFail++;
            $display("FAIL fetch_addr: got %h required %h", bus.imem_addr, expA);
        end
        repeat (ackDly) step();
        bus.imem_rdata = memWord(bus.imem_addr);
        instrQ.push_back(memWord(expA));
        bus.imem_ack = 1'b1;
        step();
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = 32'd0;
        expI = instrQ.pop_front();
        nTests++;
        if (bus.instr_valid !== 1'b1 || bus.instr !== expI || bus.imem_req !== 1'b0) begin
            nFail++;
            $display("FAIL exec_instr: valid=%b instr=%h req=%b required valid=1 instr=%h req=0",
                     bus.instr_valid, bus.instr, bus.imem_req, expI);
        end
        bus.exec_done = 1'b1;
        bus.SaltoCond = br;
        bus.oZero     = zr;
        bus.extSigno  = ext;
        bus.run       = runAfter;
        mPc = mPc + 32'd4 + ((br & zr) ? (ext << 2) : 32'd0);
        if (runAfter) addrQ.push_back(mPc);
        step();
        bus.exec_done = 1'b0;
        bus.SaltoCond = 1'b0;
        bus.oZero     = 1'b0;
        bus.extSigno  = 32'd0;
        nTests++;
        if (bus.instr_valid !== 1'b0 || bus.pc !== mPc || bus.imem_req !== runAfter) begin
            nFail++;
            $display("FAIL commit: valid=%b pc=%h req=%b required valid=0 pc=%h req=%b",
                     bus.instr_valid, bus.pc, bus.imem_req, mPc, runAfter);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idleInputs();
        #1;
        nTests++;
        if (bus.imem_req !== 1'b0 || bus.instr_valid !== 1'b0 || bus.instr !== 32'd0 ||
            bus.fault !== 1'b0 || bus.pc !== RST_PC || bus.imem_addr !== RST_PC ||
            bus.instret !== 32'd0 || bus.stall_cycles !== 32'd0) begin
            nFail++;
            $display("FAIL reset_state: req=%b valid=%b instr=%h fault=%b pc=%h addr=%h ir=%0d st=%0d required all zero, pc=%h",
                     bus.imem_req, bus.instr_valid, bus.instr, bus.fault, bus.pc,
                     bus.imem_addr, bus.instret, bus.stall_cycles, RST_PC);
        end
        doReset();
        repeat (2) step();
        nTests++;
        if (bus.imem_req !== 1'b0) begin
            nFail++;
            $display("FAIL idle_no_run: imem_req=%b required 0", bus.imem_req);
        end
    endtask

    task automatic test_sequential();
        doReset();
        bus.run = 1'b1;
        addrQ.push_back(RST_PC);
        for (int i = 0; i < 4; i++) doInstr(0, 1'b0, 1'b0, 32'd0, 1'b1);
        nTests++;
        if (bus.pc !== 32'h10) begin
            nFail++;
            $display("FAIL seq_pc: got %h required 00000010", bus.pc);
        end
    endtask

    // Continues from pc=0x10 left by test_sequential.
    task automatic test_branch();
        logic [31:0] extTab [7];
        logic [1:0]  brTab  [7];
        logic [31:0] pcTab  [7];
        extTab = '{32'h3, 32'hFFFF_FFFC, 32'h3, 32'h3, 32'hFFFF_FFF7, 32'h0, 32'h4000_0001};
        brTab  = '{2'b11, 2'b11, 2'b10, 2'b01, 2'b11, 2'b00, 2'b11};
        pcTab  = '{32'h20, 32'h14, 32'h18, 32'h1C, 32'hFFFF_FFFC, 32'h0, 32'h8};
        for (int i = 0; i < 7; i++) begin
            doInstr(i % 2, brTab[i][1], brTab[i][0], extTab[i], (i < 6) ? 1'b1 : 1'b0);
            nTests++;
            if (bus.pc !== pcTab[i]) begin
                nFail++;
                $display("FAIL branch_pc[%0d]: got %h required %h", i, bus.pc, pcTab[i]);
            end
        end
    endtask

    task automatic test_timeout();
        bit ok;
        doReset();
        bus.run = 1'b1;
        waitReq(ok);
        repeat (MAXW - 1) step();
        nTests++;
        if (!ok || bus.imem_req !== 1'b1 || bus.fault !== 1'b0) begin
            nFail++;
            $display("FAIL timeout_pre: req=%b fault=%b required req=1 fault=0", bus.imem_req, bus.fault);
        end
        step();
        nTests++;
        if (bus.fault !== 1'b1 || bus.imem_req !== 1'b0 || bus.pc !== RST_PC || bus.instr_valid !== 1'b0) begin
            nFail++;
            $display("FAIL timeout_fault: fault=%b req=%b pc=%h valid=%b required 1 0 %h 0",
                     bus.fault, bus.imem_req, bus.pc, bus.instr_valid, RST_PC);
        end
`ifdef PERF_CNT_EN
        nTests++;
        if (bus.stall_cycles !== 32'(MAXW) || bus.instret !== 32'd0) begin
            nFail++;
            $display("FAIL timeout_stall: stall=%0d instret=%0d required %0d 0",
                     bus.stall_cycles, bus.instret, MAXW);
        end
`endif
        bus.imem_ack = 1'b1;
        bus.exec_done = 1'b1;
        step();
        bus.imem_ack = 1'b0;
        bus.exec_done = 1'b0;
        step();
        nTests++;
        if (bus.fault !== 1'b1 || bus.imem_req !== 1'b0 || bus.instr_valid !== 1'b0 || bus.pc !== RST_PC) begin
            nFail++;
            $display("FAIL fault_sticky: fault=%b req=%b valid=%b pc=%h required 1 0 0 %h",
                     bus.fault, bus.imem_req, bus.instr_valid, bus.pc, RST_PC);
        end
    endtask

    task automatic test_timeout_ack();
        bit ok;
        doReset();
        bus.run = 1'b1;
        waitReq(ok);
        repeat (MAXW - 1) step();
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = memWord(RST_PC);
        step();
        bus.imem_ack   = 1'b0;
        nTests++;
        if (!ok || bus.fault !== 1'b0 || bus.instr_valid !== 1'b1 || bus.instr !== memWord(RST_PC)) begin
            nFail++;
            $display("FAIL timeout_ack: fault=%b valid=%b instr=%h required 0 1 %h",
                     bus.fault, bus.instr_valid, bus.instr, memWord(RST_PC));
        end
    endtask

    task automatic test_run_drop();
        bit ok;
        doReset();
        bus.run = 1'b1;
        addrQ.push_back(RST_PC);
        waitReq(ok);
        bus.run = 1'b0;
        doInstr(3, 1'b0, 1'b0, 32'd0, 1'b0);
        repeat (3) step();
        nTests++;
        if (!ok || bus.imem_req !== 1'b0 || bus.instr_valid !== 1'b0 || bus.pc !== RST_PC + 32'd4) begin
            nFail++;
            $display("FAIL run_drop_idle: req=%b valid=%b pc=%h required 0 0 %h",
                     bus.imem_req, bus.instr_valid, bus.pc, RST_PC + 32'd4);
        end
    endtask

    task automatic test_async_reset();
        bit ok;
        doReset();
        bus.run = 1'b1;
        addrQ.push_back(RST_PC);
        doInstr(0, 1'b0, 1'b0, 32'd0, 1'b1);
        waitReq(ok);
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'hCAFE_F00D;
        step();
        bus.imem_ack   = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        nTests++;
        if (!ok || bus.instr_valid !== 1'b0 || bus.pc !== RST_PC || bus.imem_req !== 1'b0 || bus.instr !== 32'd0) begin
            nFail++;
            $display("FAIL async_reset_exec: valid=%b pc=%h req=%b instr=%h required 0 %h 0 0",
                     bus.instr_valid, bus.pc, bus.imem_req, bus.instr, RST_PC);
        end
        step();
        reset = 1'b0;
        waitReq(ok);
        #1;
        reset = 1'b1;
        #1;
        nTests++;
        if (!ok || bus.imem_req !== 1'b0) begin
            nFail++;
            $display("FAIL async_reset_fetch: req=%b required 0", bus.imem_req);
        end
        step();
        reset = 1'b0;
        bus.run = 1'b0;
        bus.imem_ack = 1'b1;
        bus.imem_rdata = 32'h1234_5678;
        step();
        step();
        bus.imem_ack = 1'b0;
        nTests++;
        if (bus.imem_req !== 1'b0 || bus.instr_valid !== 1'b0 || bus.instr !== 32'd0 || bus.pc !== RST_PC) begin
            nFail++;
            $display("FAIL stale_ack: req=%b valid=%b instr=%h pc=%h required 0 0 0 %h",
                     bus.imem_req, bus.instr_valid, bus.instr, bus.pc, RST_PC);
        end
    endtask

    task automatic test_perf();
        doReset();
        bus.run = 1'b1;
        addrQ.push_back(RST_PC);
        for (int i = 0; i < 4; i++) doInstr(2, 1'b0, 1'b0, 32'd0, (i < 3) ? 1'b1 : 1'b0);
        nTests++;
`ifdef PERF_CNT_EN
        if (bus.instret !== 32'd4 || bus.stall_cycles !== 32'd8) begin
            nFail++;
            $display("FAIL perf_counts: instret=%0d stall=%0d required 4 8", bus.instret, bus.stall_cycles);
        end
`else
        if (bus.instret !== 32'd0 || bus.stall_cycles !== 32'd0) begin
            nFail++;
            $display("FAIL perf_tied: instret=%0d stall=%0d required 0 0", bus.instret, bus.stall_cycles);
        end
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_sequential();
        test_branch();
        test_timeout();
        test_timeout_ack();
        test_run_drop();
        test_async_reset();
        test_perf();
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
